raster_sequencer: RTL

//   Executes decoded draw commands by sequencing per-pixel writes into the 8x8 framebuffer write port.

---
 rtl/raster_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/raster_sequencer.sv
// Draw-command sequencer: queues decoded commands in a small FIFO and expands
// each one into a row-major stream of framebuffer pixel writes, honouring pix_ready.
module raster_sequencer #(
    parameter int FIFO_DEPTH = 2,
    parameter int COORD_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    input  logic [COORD_W-1:0]            x1,
    input  logic [COORD_W-1:0]            y1,
    input  logic [COORD_W-1:0]            x2,
    input  logic [COORD_W-1:0]            rect_w,
    input  logic [COORD_W-1:0]            rect_h,
    input  logic                          pix_ready,
    output logic                          pix_we,
    output logic [COORD_W-1:0]            pix_x,
    output logic [COORD_W-1:0]            pix_y,
    output logic                          pix_val,
    output logic                          busy,
    output logic                          cmd_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COORD_W-1:0] MAX_C = '1;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_PIXEL = 2'b01,
        CMD_RECT  = 2'b10,
        CMD_HLINE = 2'b11
    } cmd_e;

    typedef enum logic {IDLE, DRAW} state_e;

    typedef struct packed {
        cmd_e               op;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } entry_t;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop;
    entry_t             head;

    state_e             state, state_n;
    logic [COORD_W-1:0] xs, xe, ye;
    logic [COORD_W-1:0] win_xs, win_ys, win_xe, win_ye;
    logic               win_val;
    logic [COORD_W:0]   rx_sum, ry_sum;
    logic               accept, last;

    // ---------------- command FIFO ----------------
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = (state == IDLE) && (count != '0);
    assign push = cmd_valid && (!full || pop);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_e'(cmd), x1: x1, y1: y1, x2: x2, w: rect_w, h: rect_h};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (cmd_valid && !push) overflow <= 1'b1;
        end
    end

    // ---------------- draw window of the FIFO head ----------------
    // Sums carry one extra bit so a window running past the edge clips instead of wrapping.
    assign rx_sum = {1'b0, head.x1} + {1'b0, head.w};
    assign ry_sum = {1'b0, head.y1} + {1'b0, head.h};

    always_comb begin
        win_xs  = head.x1;
        win_ys  = head.y1;
        win_xe  = head.x1;
        win_ye  = head.y1;
        win_val = 1'b1;
        case (head.op)
            CMD_CLEAR: begin
                win_xs  = '0;
                win_ys  = '0;
                win_xe  = MAX_C;
                win_ye  = MAX_C;
                win_val = 1'b0;
            end
            CMD_PIXEL: ;
            CMD_RECT: begin
                win_xe = rx_sum[COORD_W] ? MAX_C : rx_sum[COORD_W-1:0];
                win_ye = ry_sum[COORD_W] ? MAX_C : ry_sum[COORD_W-1:0];
            end
            CMD_HLINE: begin
                win_xs = (head.x1 < head.x2) ? head.x1 : head.x2;
                win_xe = (head.x1 < head.x2) ? head.x2 : head.x1;
            end
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    assign last   = (pix_x == xe) && (pix_y == ye);
    assign accept = pix_we && pix_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pix_we  = 1'b0;
        case (state)
            IDLE: if (count != '0) state_n = DRAW;
            DRAW: begin
                pix_we = 1'b1;
                if (pix_ready && last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- cursor / working registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs       <= '0;
            xe       <= '0;
            ye       <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            pix_val  <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            cmd_done <= accept && last;
            if (pop) begin
                xs      <= win_xs;
                xe      <= win_xe;
                ye      <= win_ye;
                pix_x   <= win_xs;
                pix_y   <= win_ys;
                pix_val <= win_val;
            end else if (accept && !last) begin
                if (pix_x == xe) begin
                    pix_x <= xs;
                    pix_y <= pix_y + 1'b1;
                end else begin
                    pix_x <= pix_x + 1'b1;
                end
            end
        end
    end

    assign busy       = (count != '0) || (state != IDLE);
    assign fifo_count = count;

endmodule
